// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out shift stage.
package piso_pkg;

  // Controller state: IDLE holds no word, SHIFT is emitting one.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the beat counter for a given word length (at least one bit).
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_cell.sv
// One mux-DFF cell: L=1 captures the parallel input Rin, L=0 captures Qin.
module shift_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic L,
  input  logic Rin,
  input  logic Qin,
  output logic Q
);

  // Select-then-register; clears asynchronously to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Q <= 1'b0;
    else        Q <= L ? Rin : Qin;
  end

endmodule

// File: rtl/piso_shift_ctrl.sv
// Load/shift controller for a chain of mux-DFF cells.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Valid never depends on ready. The only combinational
// ready-from-ready path is in_ready <- ser_ready on the final bit, which
// lets a new word load in the same edge that the last bit is accepted.
//
// The FSM state is visible on busy (1 = SHIFT).
module piso_shift_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W   = cnt_w(WIDTH);
  localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_qin;
  logic               w_load;
  logic               w_beat;

  assign w_load = in_valid & in_ready;
  assign w_beat = ser_valid & ser_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: load enters SHIFT; the last beat leaves it unless a word reloads.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_load) w_next_state = SHIFT;
      SHIFT:   if (w_beat && ser_last && !w_load) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from state and counter; in_ready held low during reset.
  always_comb begin
    ser_valid = (r_state == SHIFT);
    busy      = (r_state == SHIFT);
    ser_last  = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
    in_ready  = rst_n && ((r_state == IDLE) || (ser_valid && ser_ready && ser_last));
  end

  // Beat counter: cleared on load, advanced per accepted beat, never past WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_beat) r_cnt <= ser_last ? '0 : r_cnt + 1'b1;
  end

  // Neighbour wiring: each cell takes the cell further from the output end
  // on a beat and recirculates itself otherwise; the far end fills with 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (MSB_FIRST) begin : g_msb
      if (i == 0) begin : g_end
        assign w_qin[i] = w_beat ? 1'b0 : w_q[i];
      end else begin : g_mid
        assign w_qin[i] = w_beat ? w_q[i-1] : w_q[i];
      end
    end else begin : g_lsb
      if (i == WIDTH - 1) begin : g_end
        assign w_qin[i] = w_beat ? 1'b0 : w_q[i];
      end else begin : g_mid
        assign w_qin[i] = w_beat ? w_q[i+1] : w_q[i];
      end
    end

    shift_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .L     (w_load),
      .Rin   (in_data[i]),
      .Qin   (w_qin[i]),
      .Q     (w_q[i])
    );
  end

  assign ser_out = w_q[OUT_IDX];

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Bench for piso_shift_ctrl: one MSB-first and one LSB-first instance share stimulus.
module tb_piso_shift_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         ser_ready = 1'b0;

  logic ir_m, sv_m, so_m, sl_m, bz_m;
  logic ir_l, sv_l, so_l, sl_l, bz_l;

  piso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_m),
    .in_data(in_data), .ser_valid(sv_m), .ser_ready(ser_ready),
    .ser_out(so_m), .ser_last(sl_m), .busy(bz_m)
  );

  piso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_l),
    .in_data(in_data), .ser_valid(sv_l), .ser_ready(ser_ready),
    .ser_out(so_l), .ser_last(sl_l), .busy(bz_l)
  );

  // ---------------- scoreboard / reference model ----------------
  // Each instance's pending word is a queue of bits in transmit order.
  logic [0:0] exp_q_m[$];
  logic [0:0] exp_q_l[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_in_ready();
    return rst_n && ((exp_q_m.size() == 0) || (ser_ready && exp_q_m.size() == 1));
  endfunction

  task automatic model_check();
    logic ev, eo_m, eo_l, el;
    ev   = (exp_q_m.size() != 0);
    eo_m = ev ? exp_q_m[0] : 1'b0;
    eo_l = ev ? exp_q_l[0] : 1'b0;
    el   = (exp_q_m.size() == 1);
    check("m_ser_valid", sv_m, ev);
    check("m_ser_out",   so_m, eo_m);
    check("m_ser_last",  sl_m, el);
    check("m_busy",      bz_m, ev);
    check("m_in_ready",  ir_m, model_in_ready());
    check("l_ser_valid", sv_l, ev);
    check("l_ser_out",   so_l, eo_l);
    check("l_ser_last",  sl_l, el);
    check("l_in_ready",  ir_l, model_in_ready());
  endtask

  task automatic model_update();
    logic beat, ld;
    beat = (exp_q_m.size() != 0) && ser_ready;
    ld   = in_valid && model_in_ready();
    if (beat) begin
      void'(exp_q_m.pop_front());
      void'(exp_q_l.pop_front());
    end
    if (ld) begin
      exp_q_m = {};
      exp_q_l = {};
      for (int i = W - 1; i >= 0; i--) exp_q_m.push_back(in_data[i]);
      for (int i = 0; i < W; i++)      exp_q_l.push_back(in_data[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs (just after a rising edge), then check at the falling edge.
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic sr);
    in_valid  = iv;
    in_data   = d;
    ser_ready = sr;
    @(negedge clk);
    model_check();
  endtask

  // Commit the model for the coming edge, then move past it.
  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         sr;
    logic         sv;
    logic         so_m;
    logic         so_l;
    logic         sl;
    logic         ir;
  } vec_t;

  vec_t tbl[10];
  int   beats;
  int   run_len;
  int   max_run;

  initial begin
    // Load 0xC1 at cycle 0, then 8 beats at full rate, then idle.
    tbl[0] = '{1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state while rst_n is low.
    #3;
    check("rst_ser_valid", sv_m, 1'b0);
    check("rst_ser_out",   so_m, 1'b0);
    check("rst_ser_last",  sl_m, 1'b0);
    check("rst_busy",      bz_m, 1'b0);
    check("rst_in_ready",  ir_m, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single word.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].sr);
      check("tbl_ser_valid", sv_m, tbl[i].sv);
      check("tbl_ser_out_m", so_m, tbl[i].so_m);
      check("tbl_ser_out_l", so_l, tbl[i].so_l);
      check("tbl_ser_last",  sl_m, tbl[i].sl);
      check("tbl_in_ready",  ir_m, tbl[i].ir);
      advance();
    end

    // Back-to-back: 0xA5 then 0x3C held until taken on 0xA5's last beat.
    drive(1'b1, 8'hA5, 1'b1); advance();
    run_len = 0; max_run = 0;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 8) drive(1'b1, 8'h3C, 1'b1);
      else        drive(1'b0, 8'h00, 1'b1);
      if (c == 8) check("b2b_in_ready_on_last", ir_m, 1'b1);
      if (sv_m) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      advance();
    end
    check("b2b_valid_run", max_run, 16);

    // Backpressure on cycles 3..5 of 0xC1.
    drive(1'b1, 8'hC1, 1'b1); advance();
    beats = 0;
    for (int c = 1; c <= 12; c++) begin
      drive(1'b0, 8'h00, !(c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) begin
        check("bp_frozen_out",  so_m, 1'b0);
        check("bp_frozen_last", sl_m, 1'b0);
      end
      if (c == 11) check("bp_last_cycle11", sl_m, 1'b1);
      if (c == 12) check("bp_idle_cycle12", sv_m, 1'b0);
      if (sv_m && ser_ready) beats++;
      advance();
    end
    check("bp_beats", beats, 8);

    // Blocking: offer 0xFF while stalled mid-word; it must be ignored.
    drive(1'b1, 8'hC1, 1'b1); advance();
    drive(1'b0, 8'h00, 1'b1); advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'hFF, 1'b0);
      check("block_in_ready", ir_m, 1'b0);
      advance();
    end
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 8'h00, 1'b1); advance();
    end

    // Reset mid-word after three beats of 0xC1.
    drive(1'b1, 8'hC1, 1'b1); advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 8'h00, 1'b1); advance();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_ser_valid", sv_m, 1'b0);
    check("mid_rst_ser_out",   so_m, 1'b0);
    check("mid_rst_busy",      bz_m, 1'b0);
    check("mid_rst_in_ready",  ir_m, 1'b0);
    check("mid_rst_l_valid",   sv_l, 1'b0);
    exp_q_m = {};
    exp_q_l = {};
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b1);
    check("post_rst_in_ready", ir_m, 1'b1);
    check("post_rst_no_valid", sv_m, 1'b0);
    advance();
    drive(1'b1, 8'hC1, 1'b1); advance();
    drive(1'b0, 8'h00, 1'b1);
    check("post_rst_first_bit", so_m, 1'b1);
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 8'h00, 1'b1); advance();
    end

    // Randomized traffic against the queue model.
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);
      advance();
    end
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 8'h00, 1'b1); advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
